booth_mul_arbiter: RTL

Round-robin arbiter and sequencer that shares one Booth multiplier engine between two requesters. It captures each requester's operands on grant and drives the engine's start pulse and shared 16-bit data bus: multiplicand first, multiplier second. It then waits for the engine's done, with a watchdog timeout, and returns the 32-bit signed product to the granted requester. It sits between client logic and the Booth datapath/control-path pair.

---
 rtl/booth_mul_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/booth_mul_arbiter.sv
// ============================================================================
// Module   : booth_mul_arbiter
// Purpose  : Round-robin sharing of one Booth multiplier engine by two clients
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module booth_mul_arbiter #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req,
    input  logic [WIDTH-1:0]     a0,
    input  logic [WIDTH-1:0]     b0,
    input  logic [WIDTH-1:0]     a1,
    input  logic [WIDTH-1:0]     b1,
    output logic [1:0]           gnt,
    output logic [1:0]           rsp_valid,
    output logic [2*WIDTH-1:0]   rsp_product,
    output logic                 rsp_err,
    output logic                 busy,
    output logic                 eng_start,
    output logic                 eng_rst,
    output logic [WIDTH-1:0]     eng_data_in,
    input  logic                 eng_done,
    input  logic [2*WIDTH-1:0]   eng_product
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] c_cnt_max = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_M = 3'd1,
        LOAD_Q = 3'd2,
        BUSY   = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic                 ptr_q, ptr_d;
    logic                 gidx_q, gidx_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic                 err_q, err_d;
    logic                 w_pick;

    // On a tie the requester not granted last wins; otherwise the lone one.
    assign w_pick = (req == 2'b11) ? ~ptr_q : req[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b1;
            gidx_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gidx_d      = gidx_q;
        a_d         = a_q;
        b_d         = b_q;
        cnt_d       = cnt_q;
        prod_d      = prod_q;
        err_d       = err_q;
        gnt         = 2'b00;
        rsp_valid   = 2'b00;
        eng_start   = 1'b0;
        eng_rst     = 1'b0;
        eng_data_in = '0;

        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt[w_pick] = 1'b1;
                    gidx_d      = w_pick;
                    ptr_d       = w_pick;
                    a_d         = w_pick ? a1 : a0;
                    b_d         = w_pick ? b1 : b0;
                    state_d     = LOAD_M;
                end
            end
            LOAD_M: begin
                eng_start   = 1'b1;
                eng_data_in = a_q;
                state_d     = LOAD_Q;
            end
            LOAD_Q: begin
                eng_data_in = b_q;
                cnt_d       = '0;
                state_d     = BUSY;
            end
            BUSY: begin
                eng_data_in = b_q;
                if (eng_done) begin
                    prod_d  = eng_product;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == c_cnt_max) begin
                    prod_d  = '0;
                    err_d   = 1'b1;
                    eng_rst = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                rsp_valid[gidx_q] = 1'b1;
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy        = (state_q != IDLE);
    assign rsp_product = prod_q;
    assign rsp_err     = err_q;

endmodule

`default_nettype wire
